// File: rtl/bytes2bits_stream.sv
// Byte-word to narrow-beat serializer: captures N_BYTES bytes and emits them
// LSB-first as BITS_PER_BEAT-wide beats under valid/ready handshakes.
//
// state | meaning
// IDLE  | no word held; ready for a new input word
// SHIFT | word held; beat counter selects the current beat, 0..NB-1
module bytes2bits_stream #(
  parameter int N_BYTES       = 4,
  parameter int BITS_PER_BEAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_BYTES-1:0][7:0]       bytes_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [BITS_PER_BEAT-1:0]      bits_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          last_o,
  output logic                          busy_o
);

  localparam int W  = N_BYTES * 8;
  localparam int NB = W / BITS_PER_BEAT;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            at_last;
  logic            in_xfer;
  logic            out_xfer;

  assign at_last     = (state_q == SHIFT) && (cnt_q == CW'(NB - 1));
  assign last_o      = at_last;
  assign out_valid_o = (state_q == SHIFT);
  assign busy_o      = (state_q == SHIFT);
  // Final beat may hand over to the next word in the same cycle.
  assign in_ready_o  = (state_q == IDLE) || (at_last && out_ready_i);
  // The word register shifts right per beat, so the current beat is always its low slice.
  assign bits_o      = word_q[BITS_PER_BEAT-1:0];
  assign in_xfer     = in_valid_i && in_ready_o;
  assign out_xfer    = out_valid_o && out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          state_d = SHIFT;
          word_d  = bytes_i;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (out_xfer) begin
          if (!at_last) begin
            cnt_d  = cnt_q + CW'(1);
            word_d = word_q >> BITS_PER_BEAT;
          end else if (in_xfer) begin
            word_d = bytes_i;
            cnt_d  = '0;
          end else begin
            // Clear the word so bits_o reads zero while idle.
            state_d = IDLE;
            word_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        word_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bytes2bits_stream.sv
// Directed bench for bytes2bits_stream: 1-bit, 8-bit and single-beat variants
// with hand-computed beat sequences, backpressure, back-to-back and reset cases.
module tb_bytes2bits_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // N_BYTES=4, BITS_PER_BEAT=1
  logic [3:0][7:0] a_bytes;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_busy;
  logic [0:0] a_bits;

  // N_BYTES=4, BITS_PER_BEAT=8
  logic [3:0][7:0] b_bytes;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_busy;
  logic [7:0] b_bits;

  // N_BYTES=1, BITS_PER_BEAT=8 (one beat per word)
  logic [0:0][7:0] c_bytes;
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_last, c_busy;
  logic [7:0] c_bits;

  bytes2bits_stream #(.N_BYTES(4), .BITS_PER_BEAT(1)) dut_a (
    .clk(clk), .rst(rst), .bytes_i(a_bytes), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .bits_o(a_bits), .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready), .last_o(a_last), .busy_o(a_busy));

  bytes2bits_stream #(.N_BYTES(4), .BITS_PER_BEAT(8)) dut_b (
    .clk(clk), .rst(rst), .bytes_i(b_bytes), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .bits_o(b_bits), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .last_o(b_last), .busy_o(b_busy));

  bytes2bits_stream #(.N_BYTES(1), .BITS_PER_BEAT(8)) dut_c (
    .clk(clk), .rst(rst), .bytes_i(c_bytes), .in_valid_i(c_in_valid),
    .in_ready_o(c_in_ready), .bits_o(c_bits), .out_valid_o(c_out_valid),
    .out_ready_i(c_out_ready), .last_o(c_last), .busy_o(c_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word_a(input logic [31:0] w, input bit stall, output logic [31:0] recon);
    int k;
    int cyc;
    logic [31:0] r;
    cyc = 0;
    while (!a_in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    a_bytes = w;
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_bytes = ~w;
    k = 0;
    cyc = 0;
    r = '0;
    while (k < 32 && cyc < 400) begin
      a_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("a_valid", 32'(a_out_valid), 32'd1);
      check("a_bits", 32'(a_bits), 32'(w[k]));
      check("a_last", 32'(a_last), 32'(k == 31));
      if (a_out_ready) begin
        r[k] = a_bits[0];
        k++;
      end
      tick();
      cyc++;
    end
    if (k < 32) check("a_timeout", 32'(k), 32'd32);
    a_out_ready = 1'b1;
    #1;
    check("a_idle_valid", 32'(a_out_valid), 32'd0);
    check("a_idle_busy", 32'(a_busy), 32'd0);
    check("a_idle_ready", 32'(a_in_ready), 32'd1);
    recon = r;
  endtask

  task automatic send_word_b(input logic [31:0] w, input bit stall, output logic [31:0] recon);
    int k;
    int cyc;
    logic [31:0] r;
    cyc = 0;
    while (!b_in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    b_bytes = w;
    b_in_valid = 1'b1;
    b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    b_bytes = ~w;
    k = 0;
    cyc = 0;
    r = '0;
    while (k < 4 && cyc < 100) begin
      b_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("b_bits", 32'(b_bits), 32'(w[k*8 +: 8]));
      check("b_last", 32'(b_last), 32'(k == 3));
      if (b_out_ready) begin
        r[k*8 +: 8] = b_bits;
        k++;
      end
      tick();
      cyc++;
    end
    if (k < 4) check("b_timeout", 32'(k), 32'd4);
    b_out_ready = 1'b1;
    #1;
    check("b_idle_valid", 32'(b_out_valid), 32'd0);
    recon = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] r;
    rst = 1'b1;
    a_bytes = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_bytes = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_bytes = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_last", 32'(a_last), 32'd0);
    check("rst_bits", 32'(a_bits), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(a_in_ready), 32'd1);
    check("rst_b_bits", 32'(b_bits), 32'd0);
    tick();

    // 1-bit beats, no backpressure: EF -> 1,1,1,1,0,1,1,1 ...
    send_word_a(32'h89ABCDEF, 1'b0, r);
    check("a_recon", r, 32'h89ABCDEF);

    // Same word with ~50% backpressure
    send_word_a(32'h89ABCDEF, 1'b1, r);
    check("a_bp_recon", r, 32'h89ABCDEF);

    // Back-to-back 0x00000000 then 0xFFFFFFFF
    tick();
    a_bytes = 32'h00000000;
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_bytes = 32'hFFFFFFFF;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) a_in_valid = 1'b0;
      #1;
      check("b2b_valid", 32'(a_out_valid), 32'd1);
      check("b2b_bits", 32'(a_bits), (i < 32) ? 32'd0 : 32'd1);
      check("b2b_ready", 32'(a_in_ready), 32'(i == 31 || i == 63));
      tick();
    end
    check("b2b_idle", 32'(a_out_valid), 32'd0);

    // Reset after beat 10, with a competing input transfer
    w = 32'h89ABCDEF;
    a_bytes = w;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      #1;
      check("mid_bits", 32'(a_bits), 32'(w[i]));
      tick();
    end
    rst = 1'b1;
    a_in_valid = 1'b1;
    tick();
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_bits", 32'(a_bits), 32'd0);
    check("mid_rst_last", 32'(a_last), 32'd0);
    rst = 1'b0;
    a_in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(a_out_valid), 32'd0);
    send_word_a(32'h00000001, 1'b0, r);
    check("post_rst_recon", r, 32'h00000001);

    // Round-trip of pseudo-random words with backpressure
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      send_word_a(w, 1'b1, r);
      check("a_rand_recon", r, w);
    end

    // 8-bit beats: EF, CD, AB, 89
    send_word_b(32'h89ABCDEF, 1'b0, r);
    check("b_recon", r, 32'h89ABCDEF);
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      send_word_b(w, 1'b1, r);
      check("b_rand_recon", r, w);
    end

    // Single-beat words: every beat is last, ready follows out_ready
    tick();
    c_bytes = 8'hA5;
    c_in_valid = 1'b1;
    tick();
    c_bytes = 8'h3C;
    c_out_ready = 1'b0;
    #1;
    check("c_bits0", 32'(c_bits), 32'hA5);
    check("c_last0", 32'(c_last), 32'd1);
    check("c_ready_stall", 32'(c_in_ready), 32'd0);
    tick();
    check("c_hold", 32'(c_bits), 32'hA5);
    c_out_ready = 1'b1;
    #1;
    check("c_ready_go", 32'(c_in_ready), 32'd1);
    tick();
    c_in_valid = 1'b0;
    #1;
    check("c_bits1", 32'(c_bits), 32'h3C);
    check("c_last1", 32'(c_last), 32'd1);
    check("c_valid1", 32'(c_out_valid), 32'd1);
    tick();
    check("c_idle", 32'(c_out_valid), 32'd0);
    check("c_idle_last", 32'(c_last), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
